control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Microcode control unit for the 8-bit bus CPU.
- Steps a 5-state T-cycle counter, decodes the 4-bit opcode from the instruction register and the latched CF/ZF flags, and drives every load/enable strobe on the shared bus.
- Among these are the ALU controls SU, FI and EO, which gate the adder result onto the bus and latch the flags.
- Sits between the instruction/flag registers and all bus-attached registers.

Parameters:
- NSTEPS, 5, number of T-states per instruction (T0..T4); the step counter wraps after NSTEPS-1.
- STEP_W, 3, step counter width; must satisfy 2^STEP_W >= NSTEPS.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- STEP_EN  in  1  clock enable for the sequencer (single-step/run gating); when 0, all state holds.
- OPCODE  in  4  IR[7:4], stable from T2 onward.
- CF  in  1  latched carry flag from the ALU flag register.
- ZF  in  1  latched zero flag from the ALU flag register.
- STEP  out  STEP_W  current T-state.
- HLT  out  1  halt indicator (also gates the external clock).
- MI  out  1  memory address register load.
- RI  out  1  RAM write.
- RO  out  1  RAM out to bus.
- II  out  1  instruction register load.
- IO  out  1  IR[3:0] out to bus.
- AI  out  1  A register load.
- AO  out  1  A register out to bus.
- BI  out  1  B register load.
- EO  out  1  ALU sum out to bus.
- SU  out  1  ALU subtract select.
- FI  out  1  flag register load.
- OI  out  1  output register load.
- CE  out  1  program counter increment.
- CO  out  1  program counter out to bus.
- J  out  1  program counter load (jump).

Behaviour:
- State: step counter (STEP_W bits) and halted flag.
  - Control outputs are combinational decode of (step, OPCODE, CF, ZF, halted). Moore w.r.t. step; CF/ZF only matter at T2 of JC/JZ.
- Reset (CLR_n low, asynchronous):
  - step=0, halted=0.
  - All strobes reflect the T0 decode, i.e. CO=MI=1 and all others 0.
  - HLT=0.
- Step counter:
  - On CLK rising with STEP_EN=1 and halted=0: step increments; step NSTEPS-1 wraps to 0.
  - STEP_EN=0: step and halted hold.
- Fetch (all opcodes):
  - T0: CO, MI.
  - T1: RO, II, CE.
- Execute (T2 / T3 / T4); unlisted steps drive all strobes 0:
  - 0x0 NOP: none.
  - 0x1 LDA: IO+MI / RO+AI / none.
  - 0x2 ADD: IO+MI / RO+BI / EO+AI+FI.
  - 0x3 SUB: IO+MI / RO+BI / EO+AI+FI+SU.
  - 0x4 STA: IO+MI / AO+RI / none.
  - 0x5 LDI: IO+AI.
  - 0x6 JMP: IO+J.
  - 0x7 JC: IO+J only if CF=1; otherwise no strobes.
  - 0x8 JZ: IO+J only if ZF=1; otherwise no strobes.
  - 0xE OUT: AO+OI.
  - 0xF HLT: HLT asserted combinationally at T2.
  - 0x9–0xD: treated as NOP.
- SU is asserted only together with EO. FI is never asserted without EO.
- Halt:
  - At a CLK edge in T2 with OPCODE=0xF and STEP_EN=1, halted sets.
  - While halted: step frozen at 2, HLT=1, all other strobes 0.
  - Only CLR_n clears halted.
- Bus exclusivity invariant: at most one of RO, IO, AO, EO, CO is 1 in any state.
- Reset mid-instruction: asynchronous return to T0 from any step, including while halted. No partial strobes after CLR_n deasserts.
- Flags are sampled live at T2. A flag change during T3/T4 has no effect.

Test Plan:
- Reset then release, STEP_EN=1, OPCODE=0x2:
  - STEP sequence 0,1,2,3,4,0.
  - Strobes per step: {CO,MI}, {RO,II,CE}, {IO,MI}, {RO,BI}, {EO,AI,FI}.
  - SU=0 throughout.
- OPCODE=0x3 at T4 -> EO=AI=FI=SU=1; all other strobes 0.
- OPCODE=0x7: CF=0 at T2 -> J=0, IO=0. CF=1 at T2 -> IO=J=1. Repeat with 0x8/ZF, same results.
- OPCODE=0xF:
  - T2 asserts HLT; after the next edge STEP stays 2 for 10 cycles with all strobes 0.
  - Pulse CLR_n low mid-cycle -> STEP=0 and HLT=0 immediately, CO=MI=1.
- STEP_EN=0 for 3 cycles during T3 of LDA -> STEP holds at 3 and RO=AI=1 stay asserted; STEP_EN=1 -> advances to 4.
- Sweep all 16 opcodes × 5 steps × CF/ZF: check at most one bus driver active, SU implies EO, and opcodes 0x9–0xD produce no strobes at T2–T4.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : T-state counter and microcode decode for the 8-bit bus CPU.
// Revision : 1.0
// ============================================================================
module control_sequencer #(
    parameter int NSTEPS = 5,
    parameter int STEP_W = 3
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              STEP_EN,
    input  logic [3:0]        OPCODE,
    input  logic              CF,
    input  logic              ZF,
    output logic [STEP_W-1:0] STEP,
    output logic              HLT,
    output logic              MI,
    output logic              RI,
    output logic              RO,
    output logic              II,
    output logic              IO,
    output logic              AI,
    output logic              AO,
    output logic              BI,
    output logic              EO,
    output logic              SU,
    output logic              FI,
    output logic              OI,
    output logic              CE,
    output logic              CO,
    output logic              J
);

    localparam logic [STEP_W-1:0] T0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(NSTEPS - 1);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [STEP_W-1:0] step;
    logic              halted;

    // Halting freezes the counter at T2 rather than advancing past it.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (STEP_EN && !halted) begin
            if (step == T2 && OPCODE == OP_HLT) begin
                halted <= 1'b1;
            end else if (step == LAST) begin
                step <= T0;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

    assign STEP = step;

    always_comb begin
        HLT = 1'b0; MI = 1'b0; RI = 1'b0; RO = 1'b0; II = 1'b0;
        IO  = 1'b0; AI = 1'b0; AO = 1'b0; BI = 1'b0; EO = 1'b0;
        SU  = 1'b0; FI = 1'b0; OI = 1'b0; CE = 1'b0; CO = 1'b0;
        J   = 1'b0;
        if (halted) begin
            HLT = 1'b1;
        end else begin
            case (step)
                T0: begin
                    CO = 1'b1; MI = 1'b1;
                end
                T1: begin
                    RO = 1'b1; II = 1'b1; CE = 1'b1;
                end
                T2: begin
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            IO = 1'b1; MI = 1'b1;
                        end
                        OP_LDI: begin
                            IO = 1'b1; AI = 1'b1;
                        end
                        OP_JMP: begin
                            IO = 1'b1; J = 1'b1;
                        end
                        OP_JC: begin
                            IO = CF; J = CF;
                        end
                        OP_JZ: begin
                            IO = ZF; J = ZF;
                        end
                        OP_OUT: begin
                            AO = 1'b1; OI = 1'b1;
                        end
                        OP_HLT:  HLT = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (OPCODE)
                        OP_LDA: begin
                            RO = 1'b1; AI = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            RO = 1'b1; BI = 1'b1;
                        end
                        OP_STA: begin
                            AO = 1'b1; RI = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        EO = 1'b1; AI = 1'b1; FI = 1'b1;
                        SU = (OPCODE == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
